// File: rtl/bf16_pkg.sv
// Shared types for the bfloat16 lane scheduler: lane word type, FSM state
// encoding and the divide-by-zero classifier.
package bf16_pkg;

  localparam int BF16_W = 16;

  typedef logic [BF16_W-1:0] bf16_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Zero divisor regardless of sign.
  function automatic logic is_zero(input bf16_t x);
    return (x[14:0] == 15'd0);
  endfunction

endpackage

// File: rtl/bf16_div_lane_sched.sv
// Time-multiplexes one single-lane bf16 divider across the N lanes of a vector
// divide request: one lane issued per cycle, results gathered back by lane index.
module bf16_div_lane_sched
  import bf16_pkg::*;
#(
  parameter int N       = 4,
  parameter int DIV_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BF16_W*N-1:0] in_a,
  input  logic [BF16_W*N-1:0] in_b,
  output logic                div_req,
  output logic [BF16_W-1:0]   div_a,
  output logic [BF16_W-1:0]   div_b,
  input  logic                div_rsp_valid,
  input  logic [BF16_W-1:0]   div_q,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BF16_W*N-1:0] out_q,
  output logic [N-1:0]        out_dz,
  output logic                err
);

  localparam int CW = $clog2(N + 1);
  localparam int VW = BF16_W * N;

  // A zero-latency divider would land its last response inside ISSUE.
  generate
    if (DIV_LAT < 1) begin : g_bad_div_lat
      $error("bf16_div_lane_sched: DIV_LAT must be at least 1");
    end
  endgenerate

  sched_state_t      state_q, state_d;
  logic [VW-1:0]     a_q, a_d;
  logic [VW-1:0]     b_q, b_d;
  logic [CW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]     rsp_cnt_q, rsp_cnt_d;
  logic              div_req_q, div_req_d;
  logic [BF16_W-1:0] div_a_q, div_a_d;
  logic [BF16_W-1:0] div_b_q, div_b_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [VW-1:0]     out_q_q, out_q_d;
  logic [N-1:0]      out_dz_q, out_dz_d;
  logic              err_q, err_d;
  logic [CW-1:0]     issue_nxt_s;
  logic              rsp_slot_s;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, lane mux for issue, lane demux for responses, error detection.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    issue_cnt_d = issue_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    div_req_d   = div_req_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    out_valid_d = out_valid_q;
    out_q_d     = out_q_q;
    out_dz_d    = out_dz_q;
    err_d       = err_q;
    issue_nxt_s = issue_cnt_q + CW'(1);
    rsp_slot_s  = ((state_q == ISSUE) || (state_q == DRAIN)) && (rsp_cnt_q < CW'(N));

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Lane 0 is presented straight from the inputs so issue starts next cycle.
          a_d         = in_a;
          b_d         = in_b;
          issue_cnt_d = '0;
          rsp_cnt_d   = '0;
          div_req_d   = 1'b1;
          div_a_d     = in_a[BF16_W-1:0];
          div_b_d     = in_b[BF16_W-1:0];
          for (int i = 0; i < N; i++) begin
            out_dz_d[i] = is_zero(in_b[i*BF16_W +: BF16_W]);
          end
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        issue_cnt_d = issue_nxt_s;
        if (issue_cnt_q == CW'(N - 1)) begin
          div_req_d = 1'b0;
          state_d   = DRAIN;
        end else begin
          div_a_d = a_q[int'(issue_nxt_s)*BF16_W +: BF16_W];
          div_b_d = b_q[int'(issue_nxt_s)*BF16_W +: BF16_W];
        end
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Responses are only legal while lanes are outstanding; anything else is dropped.
    if (div_rsp_valid) begin
      if (rsp_slot_s) begin
        out_q_d[int'(rsp_cnt_q)*BF16_W +: BF16_W] = div_q;
        rsp_cnt_d = rsp_cnt_q + CW'(1);
        if (rsp_cnt_q == CW'(N - 1)) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          out_valid_d = out_valid_q;
        end
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = err_q;
    end

    in_ready_d = (state_d == IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      issue_cnt_q <= '0;
      rsp_cnt_q   <= '0;
      div_req_q   <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_dz_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      issue_cnt_q <= issue_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      div_req_q   <= div_req_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q_q     <= out_q_d;
      out_dz_q    <= out_dz_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign div_req   = div_req_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign out_valid = out_valid_q;
  assign out_q     = out_q_q;
  assign out_dz    = out_dz_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bf16_div_lane_sched.sv
// Scoreboard bench for bf16_div_lane_sched with a real-arithmetic bf16 divider model.
module tb_bf16_div_lane_sched;

  localparam int N       = 4;
  localparam int DIV_LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_a, in_b;
  logic          div_req;
  logic [15:0]   div_a, div_b;
  logic          div_rsp_valid;
  logic [15:0]   div_q;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_q;
  logic [3:0]    out_dz;
  logic          err;
  logic          spur;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int hs_cyc  = 0;

  typedef struct {
    logic [63:0] q;
    logic [3:0]  dz;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] iss_q[$];

  bf16_div_lane_sched #(.N(N), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .div_req(div_req), .div_a(div_a), .div_b(div_b),
    .div_rsp_valid(div_rsp_valid), .div_q(div_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_dz(out_dz),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bf16 arithmetic reference ----------------
  function automatic real bf_to_real(input logic [15:0] x);
    real r;
    int  e;
    r = 1.0 + real'(x[6:0]) / 128.0;
    e = int'(x[14:7]) - 127;
    for (int i = 0; i < e; i++) r = r * 2.0;
    for (int i = 0; i > e; i--) r = r / 2.0;
    return x[15] ? -r : r;
  endfunction

  function automatic logic [15:0] real_to_bf(input real v);
    logic [63:0] d;
    logic [14:0] em;
    int          e;
    d  = $realtobits(v);
    e  = int'(d[62:52]) - 1023 + 127;
    em = {8'(e), d[51:45]};
    if (d[44] && ((|d[43:0]) || d[45])) em = em + 15'd1;
    return {d[63], em};
  endfunction

  function automatic logic [15:0] bf16_div(input logic [15:0] a, input logic [15:0] b);
    logic s;
    s = a[15] ^ b[15];
    if (b[14:0] == 15'd0) return (a[14:0] == 15'd0) ? 16'h7FC0 : {s, 15'h7F80};
    if (a[14:0] == 15'd0) return {s, 15'h0000};
    return real_to_bf(bf_to_real(a) / bf_to_real(b));
  endfunction

  function automatic exp_t model_vec(input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.q[i*16 +: 16] = bf16_div(a[i*16 +: 16], b[i*16 +: 16]);
      e.dz[i]         = (b[i*16 +: 15] == 15'd0);
    end
    return e;
  endfunction

  function automatic logic [15:0] rand_op(input bit is_b);
    int r;
    r = $urandom_range(0, 15);
    if (is_b && r < 2) return {r[0], 15'h0000};
    if (!is_b && r == 2) return 16'h0000;
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 7'($urandom_range(0, 127))};
  endfunction

  function automatic logic [63:0] rand_vec(input bit is_b);
    logic [63:0] v;
    for (int i = 0; i < N; i++) v[i*16 +: 16] = rand_op(is_b);
    return v;
  endfunction

  // ---------------- shared divider model ----------------
  logic [DIV_LAT-1:0] pv;
  logic [15:0]        pd [DIV_LAT];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < DIV_LAT; i++) pd[i] <= 16'h0000;
    end else begin
      pv <= {pv[DIV_LAT-2:0], div_req};
      for (int i = DIV_LAT - 1; i > 0; i--) pd[i] <= pd[i-1];
      pd[0] <= bf16_div(div_a, div_b);
    end
  end

  assign div_rsp_valid = pv[DIV_LAT-1] | spur;
  assign div_q         = pd[DIV_LAT-1];

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pushes expectations at acceptance, pops on issue and on output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model_vec(in_a, in_b));
        for (int i = 0; i < N; i++) iss_q.push_back({in_a[i*16 +: 16], in_b[i*16 +: 16]});
        acc_cyc = cyc;
      end
      if (div_req) begin
        if (iss_q.size() == 0) chk("issue_unexpected", 64'(div_req), 64'd0);
        else chk("issue_lane", {32'd0, div_a, div_b}, {32'd0, iss_q.pop_front()});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", 64'(out_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_q", out_q, e.q);
          chk("out_dz", 64'(out_dz), 64'(e.dz));
        end
        hs_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send(input logic [63:0] a, input logic [63:0] b);
    bit ok;
    ok = 1'b0;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    chk("send_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    chk("valid_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) ok = 1'b1;
    end
    chk("done_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  dreq, ov;
    logic [63:0] rec;
    bit          ok;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; spur = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_div_req", 64'(div_req), 64'd0);
    chk("rst_div_ab", {32'd0, div_a, div_b}, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_q", out_q, 64'd0);
    chk("rst_out_dz_err", {59'd0, out_dz, err}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single request: issue window and latency.
    in_a = {4{16'hC170}}; in_b = {4{16'h4120}}; in_valid = 1'b1;
    @(negedge clk);
    chk("t1_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dreq = '0; ov = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      dreq[k] = div_req;
      ov[k]   = out_valid;
    end
    chk("t1_div_req_window", 64'(dreq), 64'h01E);
    chk("t1_out_valid_cycle", 64'(ov), 64'h100);
    chk("t1_out_q", out_q, 64'hBFC0BFC0BFC0BFC0);
    chk("t1_out_dz", 64'(out_dz), 64'd0);
    @(posedge clk); #1;

    // Distinct lanes including a zero divisor.
    send({16'h4000, 16'h3F80, 16'h4080, 16'h4080}, {16'h0000, 16'h4000, 16'h3F80, 16'h4040});
    wait_done(1'b0);
    chk("t2_out_q", out_q, {16'h7F80, 16'h3F00, 16'h4080, 16'h3FAB});
    chk("t2_out_dz", 64'(out_dz), 64'h8);

    // Backpressure.
    out_ready = 1'b0;
    send(rand_vec(1'b0), rand_vec(1'b1));
    wait_valid();
    rec = out_q;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_stable", {out_q[62:0], out_valid}, {rec[62:0], 1'b1});
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_return_idle", {62'd0, in_ready, out_valid}, 64'h2);
    @(posedge clk); #1;

    // Back-to-back with in_valid held high.
    in_a = rand_vec(1'b0); in_b = rand_vec(1'b1); in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    chk("b2b_first_accept", 64'(ok), 64'd1);
    @(posedge clk); #1;
    in_a = rand_vec(1'b0); in_b = rand_vec(1'b1);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    #1;
    chk("b2b_second_accept", 64'(ok), 64'd1);
    chk("b2b_gap", 64'(acc_cyc - hs_cyc), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(1'b0);

    // Spurious divider response in IDLE.
    @(negedge clk);
    chk("err_clean", 64'(err), 64'd0);
    rec = out_q;
    @(posedge clk); #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("spur_err", 64'(err), 64'd1);
    chk("spur_out_q", out_q, rec);
    @(posedge clk); #1;
    send(rand_vec(1'b0), rand_vec(1'b1));
    wait_done(1'b0);
    chk("spur_err_sticky", 64'(err), 64'd1);

    // Reset pulse mid-DRAIN.
    send(rand_vec(1'b0), rand_vec(1'b1));
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    iss_q.delete();
    #1;
    chk("rst_mid_state", {60'd0, out_valid, in_ready, err, div_req}, 64'h4);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(rand_vec(1'b0), rand_vec(1'b1));
    wait_done(1'b0);

    // Randomized traffic with random consumer backpressure.
    for (int t = 0; t < 25; t++) begin
      send(rand_vec(1'b0), rand_vec(1'b1));
      wait_done(1'b1);
    end

    repeat (8) @(posedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("iss_empty", 64'(iss_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bf16_div_lane_sched.md
Name: bf16_div_lane_sched

Overview:
- Scheduler that shares one single-lane bfloat16 divider among the N lanes of a packed vector divide request.
- Accepts N-lane operand vectors over a valid/ready handshake, issues one lane per cycle to the shared divider, and collects results by lane.
- Presents the assembled N-lane quotient vector over a valid/ready handshake.
- Sits in front of the divider as the area-reduced alternative to N parallel divider lanes.

Parameters:
- N, 4, number of 16-bit bfloat16 lanes per request.
- DIV_LAT, 3, fixed latency in cycles from div_req to div_rsp_valid of the shared divider; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  request vector valid.
- in_ready  output  1  block can accept a request.
- in_a  input  16*N  packed dividends; lane i at bits [16*i+15:16*i].
- in_b  input  16*N  packed divisors, same packing.
- div_req  output  1  issue strobe to the shared divider.
- div_a  output  16  dividend for the issued lane.
- div_b  output  16  divisor for the issued lane.
- div_rsp_valid  input  1  divider result valid; asserted exactly DIV_LAT cycles after each div_req.
- div_q  input  16  divider quotient.
- out_valid  output  1  result vector valid.
- out_ready  input  1  consumer accepts the result.
- out_q  output  16*N  packed quotients, same packing as in_a.
- out_dz  output  N  per-lane divide-by-zero flag; set when b[14:0]==0.
- err  output  1  sticky protocol error flag.

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=1; div_req=0; div_a=div_b=0; out_valid=0; out_q=0; out_dz=0; err=0; all counters 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture in_a, in_b and per-lane dz bits into registers, then go to ISSUE.
- ISSUE:
  - Issue lane issue_cnt (0..N-1) with div_req=1 and div_a/div_b registered from the captured lane, one lane per cycle, no bubbles.
  - After lane N-1 is issued, go to DRAIN.
- DRAIN:
  - On each div_rsp_valid, write div_q into out_q lane rsp_cnt and increment rsp_cnt.
  - When lane N-1 is written, go to DONE.
  - Responses may also arrive during ISSUE (DIV_LAT<N) and are captured the same way.
- DONE:
  - out_valid=1; out_q and out_dz stay stable until the handshake.
  - On out_valid&&out_ready, clear out_valid and return to IDLE; in_ready rises the next cycle.
- in_ready=0 in ISSUE, DRAIN and DONE. No request overlap; one request is in flight at a time.
- Latency: in-accept cycle to out_valid = N + DIV_LAT + 1 cycles, with first div_req on the cycle after acceptance.
- Counters: issue_cnt and rsp_cnt are $clog2(N+1) bits and reset to 0 on entry to ISSUE.
- The dz lanes are still issued to the divider. The quotient is passed through unmodified; dz is informational only.
- Protocol error (sticky err=1, cleared only by rst):
  - div_rsp_valid arrives while in IDLE or DONE, or
  - rsp_cnt would exceed N-1.
  - The offending response is dropped.
- out_ready held high in DONE: completes in one cycle. out_ready low: hold indefinitely.
- in_valid is ignored outside IDLE; in_a/in_b need not be held after acceptance.
- rst asserted mid-operation: immediate return to reset values. The bench must not return stale divider responses after reset.

Decomposition:
- Shared package bf16_pkg:
  - bf16_t (16-bit), lane width constant BF16_W=16.
  - sched_state_t enum {IDLE, ISSUE, DRAIN, DONE}.
  - function is_zero(bf16_t) returning x[14:0]==0.
- Single module. The lane mux and demux are inline; no sub-module is needed.

Test Plan:
- Reset then single request, N=4, DIV_LAT=3:
  - Stimulus: in_a all lanes 0xC170 (-15), in_b all 0x4120 (10); bench divider model returns 0xBFC0 (-1.5).
  - Required: div_req high for cycles 1-4; out_valid at cycle 8; out_q=0xBFC0BFC0BFC0BFC0; out_dz=0.
- Distinct lanes:
  - Stimulus: in_a lanes {0x4080,0x4080,0x3F80,0x4000}, in_b {0x4040,0x3F80,0x4000,0x0000}.
  - Required: div_a/div_b appear in lane order 0..3; out_q lanes {0x3FAB,0x4080,0x3F00,0x7F80}; out_dz=4'b1000.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid.
  - Required: out_valid and out_q stable, in_ready=0; single-cycle return to IDLE after out_ready=1.
- Back-to-back requests with in_valid held high:
  - Required: second request accepted exactly the cycle after the first out handshake.
  - Required: no lane mixing between the two requests.
- Spurious div_rsp_valid in IDLE:
  - Required: err=1 and stays 1; out_q unchanged; next request completes correctly.
- rst pulse mid-DRAIN:
  - Required: out_valid=0, in_ready=1 immediately; new request after release produces correct results.
